// File: rtl/litera_pkg.sv
// Shared types and constants for the Litera cipher datapath.
//   byte_t           : 8-bit data byte
//   LITERA_TAPS      : Galois feedback mask of the keystream LFSR
//   LITERA_ZERO_SEED : substitute seed when the key is zero (an all-zero
//                      LFSR state never leaves zero)
//   state_t          : decryptor sequencing states
//   litera_step()    : one LFSR advance
package litera_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t LITERA_TAPS      = 8'hB8;
  localparam byte_t LITERA_ZERO_SEED = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic byte_t litera_step(input byte_t s);
    byte_t shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ LITERA_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/litera_keystream.sv
// Litera keystream generator: 8-bit Galois LFSR.
// The same block sits in the streaming encryptor so both ends advance in
// lockstep.
//   clk, rst_n : clock, asynchronous active-low reset (state -> 0x01)
//   load       : load seed (zero seed is replaced by LITERA_ZERO_SEED)
//   seed       : seed value, used when load is high
//   step       : advance one position (ignored while load is high)
//   k          : current keystream byte (state before the next step)
module litera_keystream
  import litera_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] k
);

  byte_t lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 8'h00) ? LITERA_ZERO_SEED : seed;
    end else if (step) begin
      lfsr_d = litera_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LITERA_ZERO_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign k = lfsr_q;

endmodule

// File: rtl/litera_stream_decrypt.sv
// Byte-serial Litera frame decryptor: ciphertext in over valid/ready,
// plaintext out over valid/ready, one frame of MSG_LEN bytes per start.
// p_i = c_i - k_i (mod 256), keystream advanced once per accepted byte.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, key          : begin a frame and latch its key (IDLE only)
//   in_valid/ready/data : ciphertext stream
//   out_valid/ready/data: plaintext stream, out_last marks the final byte
//   busy                : frame in progress
//   done                : one-cycle pulse once the last byte is consumed
module litera_stream_decrypt
  import litera_pkg::*;
#(
  parameter int MSG_LEN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] key,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(MSG_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  byte_t            out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic  accept;
  logic  out_hs;
  logic  ks_load;
  byte_t ks_k;

  // Single output register: a new byte may enter whenever the current one
  // is empty or leaving this cycle, giving full throughput with no bubble.
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign ks_load  = (state_q == IDLE) && start;

  litera_keystream u_keystream (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ks_load),
    .seed  (key),
    .step  (accept),
    .k     (ks_k)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data - ks_k;
          out_last_d  = (cnt_q == LAST_IDX);
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end else if (out_hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_litera_stream_decrypt.sv
module tb_litera_stream_decrypt;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [2:0]      start_s, in_valid_s, out_ready_s;
  logic [2:0]      in_ready_s, out_valid_s, out_last_s, busy_s, done_s;
  logic [2:0][7:0] key_s, in_data_s, out_data_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Three instances: MSG_LEN 1, 2 and 5.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    litera_stream_decrypt #(.MSG_LEN(g == 0 ? 1 : (g == 1 ? 2 : 5))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_s[g]),
      .key       (key_s[g]),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .in_data   (in_data_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .out_data  (out_data_s[g]),
      .out_last  (out_last_s[g]),
      .busy      (busy_s[g]),
      .done      (done_s[g])
    );
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_in_ready"},  8'(in_ready_s[i]),  8'h00);
    chk({tag, "_out_valid"}, 8'(out_valid_s[i]), 8'h00);
    chk({tag, "_out_data"},  out_data_s[i],      8'h00);
    chk({tag, "_out_last"},  8'(out_last_s[i]),  8'h00);
    chk({tag, "_busy"},      8'(busy_s[i]),      8'h00);
    chk({tag, "_done"},      8'(done_s[i]),      8'h00);
  endtask

  // Reference: plaintext from ciphertext and key using the cipher rules.
  function automatic bq_t ref_decrypt(input logic [7:0] k, input bq_t ct);
    bq_t p;
    logic [7:0] s;
    s = (k == 8'h00) ? 8'h01 : k;
    foreach (ct[j]) begin
      p.push_back(ct[j] - s);
      s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    end
    return p;
  endfunction

  // Runs one frame on instance i with a cycle-by-cycle stream scoreboard.
  // rnd: random valid/ready; poke: pulse start with another key mid-frame.
  task automatic run_frame(input int i, input logic [7:0] k, input bq_t ct,
                           input bit rnd, input bit poke);
    bq_t want;
    int  len, sent, rcv, cyc;
    bit  prev_stall, v, r;
    logic [7:0] prev_d;
    logic prev_l;
    want = ref_decrypt(k, ct);
    len = ct.size();
    sent = 0; rcv = 0; cyc = 0; prev_stall = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    start_s[i] = 1'b1;
    key_s[i] = k;
    @(posedge clk); #1;
    start_s[i] = 1'b0;
    chk("busy_after_start", 8'(busy_s[i]), 8'h01);
    while (rcv < len && cyc < 300) begin
      in_valid_s[i]  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data_s[i]   = (sent < len) ? ct[sent] : 8'($urandom);
      out_ready_s[i] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      start_s[i]     = poke && (cyc == 1);
      key_s[i]       = (poke && (cyc == 1)) ? ~k : k;
      #1;
      if (prev_stall) begin
        chk("stall_data_held", out_data_s[i], prev_d);
        chk("stall_last_held", 8'(out_last_s[i]), 8'(prev_l));
      end
      chk("out_valid", 8'(out_valid_s[i]), 8'(sent > rcv));
      chk("in_ready", 8'(in_ready_s[i]),
          8'((sent < len) && (!(sent > rcv) || out_ready_s[i])));
      chk("busy_in_frame", 8'(busy_s[i]), 8'h01);
      v = in_valid_s[i] && in_ready_s[i];
      r = out_valid_s[i] && out_ready_s[i];
      if (r) begin
        chk("out_data", out_data_s[i], want[rcv]);
        chk("out_last", 8'(out_last_s[i]), 8'(rcv == len - 1));
      end
      prev_stall = out_valid_s[i] && !out_ready_s[i];
      prev_d = out_data_s[i];
      prev_l = out_last_s[i];
      if (v) sent++;
      if (r) rcv++;
      start_s[i] = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_s[i] = 1'b0;
    key_s[i] = k;
    chk("frame_completed", 8'(rcv == len), 8'h01);
    chk("done_pulse", 8'(done_s[i]), 8'h01);
    chk("busy_at_done", 8'(busy_s[i]), 8'h00);
    @(posedge clk); #1;
    chk("done_one_cycle", 8'(done_s[i]), 8'h00);
  endtask

  initial begin
    bq_t q;
    start_s = '0; in_valid_s = '0; out_ready_s = '0;
    key_s = '0; in_data_s = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_idle(i, "reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MSG_LEN=1, key A5, F5 -> 'P'
    q = {8'hF5};
    run_frame(0, 8'hA5, q, 1'b0, 1'b0);

    // MSG_LEN=2 back-to-back -> "PQ"
    q = {8'hF5, 8'h3B};
    run_frame(1, 8'hA5, q, 1'b0, 1'b0);

    // Backpressure on MSG_LEN=2
    start_s[1] = 1'b1; key_s[1] = 8'hA5;
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    in_valid_s[1] = 1'b1; in_data_s[1] = 8'hF5; out_ready_s[1] = 1'b0;
    @(posedge clk); #1;
    in_data_s[1] = 8'h3B;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", 8'(in_ready_s[1]), 8'h00);
      chk("bp_out_valid", 8'(out_valid_s[1]), 8'h01);
      chk("bp_hold_data", out_data_s[1], 8'h50);
      chk("bp_hold_last", 8'(out_last_s[1]), 8'h00);
      @(posedge clk); #1;
    end
    out_ready_s[1] = 1'b1;
    #1;
    chk("bp_release_in_ready", 8'(in_ready_s[1]), 8'h01);
    @(posedge clk); #1;
    in_valid_s[1] = 1'b0;
    chk("bp_second_data", out_data_s[1], 8'h51);
    chk("bp_second_last", 8'(out_last_s[1]), 8'h01);
    chk("bp_second_valid", 8'(out_valid_s[1]), 8'h01);
    @(posedge clk); #1;
    chk("bp_done", 8'(done_s[1]), 8'h01);
    @(posedge clk); #1;
    chk("bp_done_cleared", 8'(done_s[1]), 8'h00);

    // key 0 -> seed 0x01
    q = {8'h51};
    run_frame(0, 8'h00, q, 1'b0, 1'b0);

    // Reset mid-frame after one of two bytes
    start_s[1] = 1'b1; key_s[1] = 8'hA5;
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    in_valid_s[1] = 1'b1; in_data_s[1] = 8'hF5; out_ready_s[1] = 1'b0;
    @(posedge clk); #1;
    in_valid_s[1] = 1'b0;
    chk("midrst_pre_valid", 8'(out_valid_s[1]), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk_idle(1, "midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 8'(done_s[1]), 8'h00);
    end
    q = {8'hF5, 8'h3B};
    run_frame(1, 8'hA5, q, 1'b0, 1'b0);

    // Random frames; first MSG_LEN=5 frame has a start/key poke mid-frame
    for (int r = 0; r < 6; r++) begin
      q = {};
      for (int j = 0; j < 5; j++) q.push_back(8'($urandom));
      run_frame(2, (r == 1) ? 8'h00 : 8'($urandom), q, 1'b1, r == 0);
    end
    for (int r = 0; r < 4; r++) begin
      q = {8'($urandom), 8'($urandom)};
      run_frame(1, 8'($urandom), q, 1'b1, 1'b0);
    end
    for (int r = 0; r < 3; r++) begin
      q = {8'($urandom)};
      run_frame(0, 8'($urandom), q, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/litera_stream_decrypt.md
Name: litera_stream_decrypt

Overview:
- Byte-serial, clocked decryptor for Litera-cipher frames of MSG_LEN bytes; receiving end of the streaming Litera encryptor.
- Accepts ciphertext bytes over a valid/ready input stream and emits plaintext bytes over a valid/ready output stream.
- Replaces the combinational whole-array decrypt in the datapath to UART/LED output.

Parameters:
- MSG_LEN, 1, bytes per frame (>=1).
- CNT_W, $clog2(MSG_LEN+1), byte-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame and latches key (honoured in IDLE only).
- key  in  8  frame key; sampled on start.
- in_valid  in  1  ciphertext byte valid.
- in_ready  out  1  decryptor can accept a byte.
- in_data  in  8  ciphertext byte.
- out_valid  out  1  plaintext byte valid.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  plaintext byte.
- out_last  out  1  qualifies the final byte of the frame (with out_valid).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last plaintext byte is consumed.

Behaviour:
- Reset (async assert, sync release) values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0; FSM=IDLE; counter=0; LFSR=0x01.
- Keystream: 8-bit Galois LFSR, taps 0xB8.
  - Step: lsb=s[0]; s=s>>1; if lsb then s^=0xB8.
  - Seed = key on start; key==0 seeds 0x01 to avoid lockup.
  - k_i is the state before step i. The LFSR steps exactly once per accepted input byte.
- Arithmetic: p_i = (c_i - k_i) mod 256, 8-bit wrap, no saturation.
- FSM states:
  - IDLE: start -> RUN; latch seed; counter=0.
  - RUN: in_ready = !out_valid || out_ready. On in_valid&&in_ready:
    - register p into out_data; out_valid=1 next cycle;
    - counter++; step LFSR;
    - out_last=1 when counter==MSG_LEN-1.
    - When the MSG_LEN-th byte is accepted -> DRAIN.
  - DRAIN: in_ready=0; hold the output until out_valid&&out_ready -> DONE.
  - DONE: done=1 for one cycle; busy=0 -> IDLE.
- Latency: accepted byte appears on out_data the next cycle. Throughput is 1 byte/clk while out_ready=1.
- Output stability: out_data and out_last stay stable while out_valid && !out_ready.
- Simultaneous events: an output handshake and an input accept in the same cycle replace the output register with no bubble.
- in_ready is 0 in IDLE, DRAIN and DONE. in_valid bytes there are not consumed.
- start while busy is ignored; key changes mid-frame are ignored.
- Reset mid-frame: the in-flight byte is discarded, all outputs return to reset values, and no done pulse is issued.
- MSG_LEN=1: a single accept goes straight to DRAIN with out_last=1.

Decomposition:
- litera_pkg:
  - typedef byte_t (logic [7:0]);
  - localparam LITERA_TAPS=8'hB8;
  - localparam LITERA_ZERO_SEED=8'h01;
  - FSM enum state_t {IDLE, RUN, DRAIN, DONE}.
- Sub-module litera_keystream (clk, rst_n, load, seed, step, k): the LFSR. The streaming encryptor shares it so both ends stay in lockstep.

Test Plan:
- MSG_LEN=1, key=0xA5, in_data=0xF5, out_ready=1 -> next cycle out_data=0x50 ('P'), out_last=1; done one cycle after the handshake.
- MSG_LEN=2, key=0xA5, bytes 0xF5,0x3B back-to-back -> out_data 0x50,0x51 ("PQ") on consecutive cycles; out_last only on 0x51.
- Backpressure: MSG_LEN=2, out_ready=0 for 3 cycles after first output -> in_ready=0, out_data held at 0x50, LFSR not advanced; release gives 0x51.
- key=0x00, MSG_LEN=1, in_data=0x51 -> out_data=0x50 (seed forced 0x01).
- Reset mid-frame after 1 of 2 bytes -> all outputs zero, no done pulse. A new start with key=0xA5 and 0xF5 gives 0x50.
- start pulsed during RUN with a different key -> ignored; the frame decrypts with the original key.
